branch_resolve_unit: RTL and testbench

- Execute-stage responder to the predicting fetch stage.
- Captures each instruction's prediction metadata from IF/ID into its own ID/EX metadata register and resolves beq/bne in E.
- Drives the training/update signals back to the GHR, PHT and BTB (branch_E, bne_E, real_Value_E, Pc_E, Pc_Xor_GR_E).
- Drives the misprediction recovery controls (flush, selectCorrectTarget, selectCorrectPcPlus1, select_hit), and keeps saturating branch/mispredict counters.

---
 rtl/branch_resolve_unit.sv | 155 +++++++++++++++
 tb/tb_branch_resolve_unit.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: holds ID/EX prediction metadata, resolves beq/bne in E,
// drives predictor training, misprediction recovery and perf counters.
module branch_resolve_unit #(
  parameter int PC_W  = 5,
  parameter int GHR_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ID_EX_write,
  input  logic             flush_in,
  input  logic [5:0]       opcode_D,
  input  logic             prediction_D,
  input  logic             hit_D,
  input  logic [GHR_W-1:0] GHR_D,
  input  logic [PC_W-1:0]  Pc_D,
  input  logic [31:0]      rs_val_E,
  input  logic [31:0]      rt_val_E,
  output logic             branch_E,
  output logic             bne_E,
  output logic             real_Value_E,
  output logic [PC_W-1:0]  Pc_E,
  output logic [GHR_W-1:0] Pc_Xor_GR_E,
  output logic             flush,
  output logic             selectCorrectTarget,
  output logic             select_hit,
  output logic             selectCorrectPcPlus1,
  output logic [CNT_W-1:0] branch_count,
  output logic [CNT_W-1:0] mispredict_count
);

  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_BNE = 6'b000101;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic             valid_q, valid_d;
  logic             beq_q, beq_d;
  logic             bne_q, bne_d;
  logic             pred_q, pred_d;
  logic             hit_q, hit_d;
  logic             res_q, res_d;
  logic [GHR_W-1:0] ghr_q, ghr_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [CNT_W-1:0] bcnt_q, bcnt_d;
  logic [CNT_W-1:0] mcnt_q, mcnt_d;

  logic is_beq_D, is_bne_D;
  logic eq, taken, act, eff_pred;
  logic mis_t, mis_n;

  // Decode the D opcode into branch kinds
  always_comb begin
    is_beq_D = 1'b0;
    is_bne_D = 1'b0;
    unique case (opcode_D)
      OP_BEQ:  is_beq_D = 1'b1;
      OP_BNE:  is_bne_D = 1'b1;
      default: ;
    endcase
  end

  // Resolve the E branch and detect a misprediction
  always_comb begin
    eq       = (rs_val_E == rt_val_E);
    taken    = (beq_q & eq) | (bne_q & ~eq);
    act      = valid_q & (beq_q | bne_q) & ~res_q;
    eff_pred = pred_q & hit_q;
    mis_t    = act & taken & ~eff_pred;
    mis_n    = act & ~taken & eff_pred;
  end

  assign branch_E             = act & beq_q;
  assign bne_E                = act & bne_q;
  assign real_Value_E         = act & taken;
  assign Pc_E                 = pc_q;
  assign Pc_Xor_GR_E          = pc_q[GHR_W-1:0] ^ ghr_q;
  assign flush                = mis_t | mis_n;
  assign selectCorrectTarget  = mis_t;
  assign select_hit           = mis_t;
  assign selectCorrectPcPlus1 = mis_n;
  assign branch_count         = bcnt_q;
  assign mispredict_count     = mcnt_q;

  // ID/EX metadata next state: bubble, load or hold; resolved
  // blocks repeated updates while a fired branch sits stalled in E
  always_comb begin
    valid_d = valid_q;
    beq_d   = beq_q;
    bne_d   = bne_q;
    pred_d  = pred_q;
    hit_d   = hit_q;
    res_d   = res_q;
    ghr_d   = ghr_q;
    pc_d    = pc_q;
    if (ID_EX_write && (flush_in || flush)) begin
      valid_d = 1'b0;
      beq_d   = 1'b0;
      bne_d   = 1'b0;
      pred_d  = 1'b0;
      hit_d   = 1'b0;
      res_d   = 1'b0;
      ghr_d   = '0;
      pc_d    = '0;
    end else if (ID_EX_write) begin
      valid_d = 1'b1;
      beq_d   = is_beq_D;
      bne_d   = is_bne_D;
      pred_d  = prediction_D;
      hit_d   = hit_D;
      res_d   = 1'b0;
      ghr_d   = GHR_D;
      pc_d    = Pc_D;
    end else if (act) begin
      res_d   = 1'b1;
    end
  end

  // Saturating branch and mispredict counters
  always_comb begin
    bcnt_d = bcnt_q;
    mcnt_d = mcnt_q;
    if (act && (bcnt_q != '1))
      bcnt_d = bcnt_q + CNT_ONE;
    if (flush && (mcnt_q != '1))
      mcnt_d = mcnt_q + CNT_ONE;
  end

  // State registers with asynchronous clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      beq_q   <= 1'b0;
      bne_q   <= 1'b0;
      pred_q  <= 1'b0;
      hit_q   <= 1'b0;
      res_q   <= 1'b0;
      ghr_q   <= '0;
      pc_q    <= '0;
      bcnt_q  <= '0;
      mcnt_q  <= '0;
    end else begin
      valid_q <= valid_d;
      beq_q   <= beq_d;
      bne_q   <= bne_d;
      pred_q  <= pred_d;
      hit_q   <= hit_d;
      res_q   <= res_d;
      ghr_q   <= ghr_d;
      pc_q    <= pc_d;
      bcnt_q  <= bcnt_d;
      mcnt_q  <= mcnt_d;
    end
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: directed E-stage vectors,
// expectations queued by stimulus and checked by a negedge monitor.
module tb_branch_resolve_unit;

  localparam int PC_W  = 5;
  localparam int GHR_W = 4;
  localparam int CNT_W = 4;

  localparam logic [5:0] BEQ = 6'b000100;
  localparam logic [5:0] BNE = 6'b000101;
  localparam logic [5:0] ADD = 6'b000000;

  logic             clk = 1'b0;
  logic             reset;
  logic             ID_EX_write;
  logic             flush_in;
  logic [5:0]       opcode_D;
  logic             prediction_D;
  logic             hit_D;
  logic [GHR_W-1:0] GHR_D;
  logic [PC_W-1:0]  Pc_D;
  logic [31:0]      rs_val_E;
  logic [31:0]      rt_val_E;
  logic             branch_E;
  logic             bne_E;
  logic             real_Value_E;
  logic [PC_W-1:0]  Pc_E;
  logic [GHR_W-1:0] Pc_Xor_GR_E;
  logic             flush;
  logic             selectCorrectTarget;
  logic             select_hit;
  logic             selectCorrectPcPlus1;
  logic [CNT_W-1:0] branch_count;
  logic [CNT_W-1:0] mispredict_count;

  branch_resolve_unit #(
    .PC_W (PC_W),
    .GHR_W(GHR_W),
    .CNT_W(CNT_W)
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .ID_EX_write         (ID_EX_write),
    .flush_in            (flush_in),
    .opcode_D            (opcode_D),
    .prediction_D        (prediction_D),
    .hit_D               (hit_D),
    .GHR_D               (GHR_D),
    .Pc_D                (Pc_D),
    .rs_val_E            (rs_val_E),
    .rt_val_E            (rt_val_E),
    .branch_E            (branch_E),
    .bne_E               (bne_E),
    .real_Value_E        (real_Value_E),
    .Pc_E                (Pc_E),
    .Pc_Xor_GR_E         (Pc_Xor_GR_E),
    .flush               (flush),
    .selectCorrectTarget (selectCorrectTarget),
    .select_hit          (select_hit),
    .selectCorrectPcPlus1(selectCorrectPcPlus1),
    .branch_count        (branch_count),
    .mispredict_count    (mispredict_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0]      o;
    logic [CNT_W-1:0] bc;
    logic [CNT_W-1:0] mc;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  logic [CNT_W-1:0] ebc = '0;
  logic [CNT_W-1:0] emc = '0;

  // {branch, bne, real, flush, selT, selHit, selP1, Pc_E, Pc_Xor}
  function automatic logic [15:0] ev(
    input logic b, n, r, f, t, h, p,
    input logic [4:0] pc,
    input logic [3:0] x
  );
    return {b, n, r, f, t, h, p, pc, x};
  endfunction

  function automatic logic [CNT_W-1:0] sat(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  // Drive one cycle: E operands and D inputs, queue the E expectation
  task automatic cyc(
    input logic        rst, wr, fin,
    input logic [5:0]  op,
    input logic        pr, ht,
    input logic [3:0]  gh,
    input logic [4:0]  pc,
    input logic [31:0] rs, rt,
    input logic [15:0] e
  );
    exp_t x;
    @(posedge clk);
    #1;
    reset        = rst;
    ID_EX_write  = wr;
    flush_in     = fin;
    opcode_D     = op;
    prediction_D = pr;
    hit_D        = ht;
    GHR_D        = gh;
    Pc_D         = pc;
    rs_val_E     = rs;
    rt_val_E     = rt;
    if (rst) begin
      ebc = '0;
      emc = '0;
    end
    x.o  = e;
    x.bc = ebc;
    x.mc = emc;
    q.push_back(x);
    if (e[15] | e[14]) ebc = sat(ebc);
    if (e[12]) emc = sat(emc);
  endtask

  // Monitor: compare outputs against the queued expectation
  always @(negedge clk) begin
    exp_t x;
    logic [15:0] act;
    if (q.size() > 0) begin
      x = q.pop_front();
      act = {branch_E, bne_E, real_Value_E, flush,
             selectCorrectTarget, select_hit,
             selectCorrectPcPlus1, Pc_E, Pc_Xor_GR_E};
      n_chk++;
      if (act === x.o) n_pass++;
      else $display("FAIL outs t=%0t got %h want %h", $time, act, x.o);
      n_chk++;
      if (branch_count === x.bc && mispredict_count === x.mc) n_pass++;
      else $display("FAIL cnts t=%0t got %0d/%0d want %0d/%0d", $time,
                    branch_count, mispredict_count, x.bc, x.mc);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    reset        = 1'b1;
    ID_EX_write  = 1'b0;
    flush_in     = 1'b0;
    opcode_D     = ADD;
    prediction_D = 1'b0;
    hit_D        = 1'b0;
    GHR_D        = '0;
    Pc_D         = '0;
    rs_val_E     = '0;
    rt_val_E     = '0;

    // reset state
    cyc(1, 0, 0, ADD, 0, 0, 4'h0, 5'h00, 0, 0,
        ev(0,0,0,0,0,0,0, 5'h00, 4'h0));
    cyc(0, 1, 0, BEQ, 1, 1, 4'h0, 5'h02, 0, 0,
        ev(0,0,0,0,0,0,0, 5'h00, 4'h0));
    // beq correctly predicted taken
    cyc(0, 1, 0, BNE, 0, 0, 4'hA, 5'h13, 32'h5, 32'h5,
        ev(1,0,1,0,0,0,0, 5'h02, 4'h2));
    // bne taken, predicted not taken
    cyc(0, 1, 0, ADD, 0, 0, 4'h0, 5'h00, 32'h1, 32'h2,
        ev(0,1,1,1,1,1,0, 5'h13, 4'h9));
    // bubble from own flush
    cyc(0, 1, 0, BEQ, 1, 1, 4'h3, 5'h04, 32'h1, 32'h2,
        ev(0,0,0,0,0,0,0, 5'h00, 4'h0));
    // beq predicted taken, not taken
    cyc(0, 1, 0, BEQ, 1, 0, 4'h0, 5'h06, 32'h1, 32'h2,
        ev(1,0,0,1,0,0,1, 5'h04, 4'h7));
    cyc(0, 1, 0, BEQ, 1, 0, 4'h0, 5'h06, 32'h1, 32'h2,
        ev(0,0,0,0,0,0,0, 5'h00, 4'h0));
    // beq pred=1 but BTB miss, not taken: no flush
    cyc(0, 1, 0, BNE, 1, 1, 4'h1, 5'h08, 32'h1, 32'h2,
        ev(1,0,0,0,0,0,0, 5'h06, 4'h6));
    // mispredicting bne held in E for three cycles
    cyc(0, 0, 0, ADD, 0, 0, 4'h5, 5'h0A, 32'h7, 32'h7,
        ev(0,1,0,1,0,0,1, 5'h08, 4'h9));
    cyc(0, 0, 0, ADD, 0, 0, 4'h5, 5'h0A, 32'h7, 32'h7,
        ev(0,0,0,0,0,0,0, 5'h08, 4'h9));
    cyc(0, 1, 0, ADD, 0, 0, 4'h5, 5'h0A, 32'h7, 32'h7,
        ev(0,0,0,0,0,0,0, 5'h08, 4'h9));
    // non-branch in E
    cyc(0, 1, 0, BNE, 0, 0, 4'h0, 5'h01, 32'h7, 32'h7,
        ev(0,0,0,0,0,0,0, 5'h0A, 4'hF));
    // drive both counters into saturation
    for (int i = 0; i < 13; i++) begin
      cyc(0, 1, 0, BNE, 0, 0, 4'h0, 5'h01, 32'h1, 32'h2,
          ev(0,1,1,1,1,1,0, 5'h01, 4'h1));
      if (i == 12)
        cyc(0, 1, 1, BEQ, 1, 1, 4'h0, 5'h01, 32'h1, 32'h2,
            ev(0,0,0,0,0,0,0, 5'h00, 4'h0));
      else
        cyc(0, 1, 0, BNE, 0, 0, 4'h0, 5'h01, 32'h1, 32'h2,
            ev(0,0,0,0,0,0,0, 5'h00, 4'h0));
    end
    // flush_in squashed the loaded beq
    cyc(0, 1, 0, BNE, 0, 0, 4'h2, 5'h03, 32'h1, 32'h2,
        ev(0,0,0,0,0,0,0, 5'h00, 4'h0));
    // own flush and flush_in together
    cyc(0, 1, 1, BEQ, 1, 1, 4'h0, 5'h01, 32'h1, 32'h2,
        ev(0,1,1,1,1,1,0, 5'h03, 4'h1));
    cyc(0, 1, 0, BEQ, 1, 1, 4'hF, 5'h1F, 32'h1, 32'h2,
        ev(0,0,0,0,0,0,0, 5'h00, 4'h0));
    // stalled beq, then reset mid-stall
    cyc(0, 0, 0, ADD, 0, 0, 4'h0, 5'h00, 32'h9, 32'h9,
        ev(1,0,1,0,0,0,0, 5'h1F, 4'h0));
    cyc(1, 1, 0, BEQ, 0, 1, 4'h1, 5'h02, 32'h9, 32'h9,
        ev(0,0,0,0,0,0,0, 5'h00, 4'h0));
    cyc(0, 1, 0, BEQ, 0, 1, 4'h1, 5'h02, 32'h9, 32'h9,
        ev(0,0,0,0,0,0,0, 5'h00, 4'h0));
    // first load after reset
    cyc(0, 1, 0, ADD, 0, 0, 4'h0, 5'h00, 32'h9, 32'h9,
        ev(1,0,1,1,1,1,0, 5'h02, 4'h3));
    cyc(0, 0, 0, ADD, 0, 0, 4'h0, 5'h00, 32'h9, 32'h9,
        ev(0,0,0,0,0,0,0, 5'h00, 4'h0));

    repeat (3) @(posedge clk);
    n_chk++;
    if (q.size() == 0) n_pass++;
    else $display("FAIL drain left %0d want 0", q.size());
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
